// File: rtl/corr_pkg.sv
// corr_pkg: shared widths and pio_word bit positions for the correlator result path
package corr_pkg;
  localparam int CORR_TIM_W = 14;
  localparam int CORR_FIFO_DEPTH = 8;
  localparam int OVF_BIT = CORR_TIM_W + 1;
  localparam int VALID_BIT = CORR_TIM_W;
endpackage

// File: rtl/corr_sync_fifo.sv
// corr_sync_fifo: W x DEPTH synchronous FIFO with first-word-fall-through head, zero when empty
module corr_sync_fifo #(
  parameter int W = 14,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] count_q;
  logic wr, rd;
  assign full_o = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign rd = pop_i & ~empty_o;
  // When full, a same-cycle pop frees the slot the push lands in
  assign wr = push_i & (~full_o | rd);
  assign head_o = empty_o ? '0 : mem_q[rptr_q];
  always_ff @(posedge clk)
    if (wr) mem_q[wptr_q] <= din_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      if (wr) wptr_q <= wptr_q + AW'(1);
      if (rd) rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/corr_result_fifo.sv
// corr_result_fifo: queues correlator results on rdy rising edges and presents {ovf, valid, head} to the PIO,
// popping one entry per ack_tgl level change
module corr_result_fifo
  import corr_pkg::*;
#(
  parameter int W = CORR_TIM_W,
  parameter int DEPTH = CORR_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic [W-1:0]            tim,
  input  logic                    ack_tgl,
  input  logic                    clr_ovf,
  output logic [W+1:0]            pio_word,
  output logic [$clog2(DEPTH):0]  count
);
  logic rdy_q, ack_q, ovf_q, ovf_d;
  logic push, pop, full, empty, valid;
  logic [W-1:0] head;
  assign valid = ~empty;
  assign push = rdy & ~rdy_q;
  assign pop = (ack_tgl ^ ack_q) & valid;
  assign ovf_d = (push & full & ~pop) ? 1'b1 : clr_ovf ? 1'b0 : ovf_q;
  assign pio_word = {ovf_q, valid, head};
  // Edge/toggle references track their inputs even in reset so release causes no spurious event
  always_ff @(posedge clk) begin
    rdy_q <= rdy;
    ack_q <= ack_tgl;
    ovf_q <= rst ? 1'b0 : ovf_d;
  end
  corr_sync_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .pop_i(pop),
    .din_i(tim),
    .head_o(head),
    .full_o(full),
    .empty_o(empty),
    .count_o(count)
  );
endmodule

// File: tb/tb_corr_result_fifo.sv
// tb_corr_result_fifo: directed self-checking bench for corr_result_fifo
module tb_corr_result_fifo;
  import corr_pkg::*;
  logic clk = 0, rst, rdy, ack_tgl, clr_ovf;
  logic [13:0] tim;
  logic [15:0] pio_word;
  logic [3:0] count;
  int errors = 0, checks = 0;
  corr_result_fifo dut (
    .clk(clk), .rst(rst), .rdy(rdy), .tim(tim), .ack_tgl(ack_tgl),
    .clr_ovf(clr_ovf), .pio_word(pio_word), .count(count)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic pulse(input logic [13:0] v);
    tim = v;
    rdy = 1;
    step();
    rdy = 0;
    step();
  endtask
  task automatic toggle;
    ack_tgl = ~ack_tgl;
    step();
  endtask
  initial begin
    rst = 1; rdy = 1; tim = '0; ack_tgl = 0; clr_ovf = 0;
    step(); step();
    rst = 0;
    step();
    chk("reset_rdy_high_count", 32'(count), 0);
    chk("reset_rdy_high_pio", 32'(pio_word), 0);
    rdy = 0;
    step();
    pulse(14'h1A5);
    chk("single_pio", 32'(pio_word), 32'h41A5);
    chk("single_count", 32'(count), 1);
    toggle();
    chk("single_pop_pio", 32'(pio_word), 0);
    chk("single_pop_count", 32'(count), 0);
    for (int i = 1; i <= 8; i++) pulse(14'(i));
    chk("fill_count", 32'(count), 8);
    chk("fill_pio", 32'(pio_word), 32'h4001);
    pulse(14'h3FFF);
    chk("ovf_count", 32'(count), 8);
    chk("ovf_pio", 32'(pio_word), 32'hC001);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_head%0d", i), 32'(pio_word[13:0]), 32'(i));
      toggle();
    end
    chk("drained_pio", 32'(pio_word), 32'h8000);
    chk("drained_ovf_bit", 32'(pio_word[OVF_BIT]), 1);
    clr_ovf = 1;
    step();
    clr_ovf = 0;
    chk("clr_ovf_pio", 32'(pio_word), 0);
    for (int i = 0; i < 8; i++) pulse(14'h10 + 14'(i));
    tim = 14'h55; rdy = 1; ack_tgl = ~ack_tgl;
    step();
    rdy = 0;
    step();
    chk("full_pushpop_count", 32'(count), 8);
    chk("full_pushpop_pio", 32'(pio_word), 32'h4011);
    for (int i = 1; i < 8; i++) toggle();
    chk("full_pushpop_last", 32'(pio_word), 32'h4055);
    chk("full_pushpop_last_count", 32'(count), 1);
    toggle();
    chk("empty_again", 32'(pio_word), 0);
    toggle();
    chk("empty_toggle_count", 32'(count), 0);
    step();
    tim = 14'h42; rdy = 1; ack_tgl = ~ack_tgl;
    step();
    rdy = 0;
    step();
    chk("push_empty_toggle_pio", 32'(pio_word), 32'h4042);
    chk("push_empty_toggle_count", 32'(count), 1);
    for (int i = 0; i < 7; i++) pulse(14'h20 + 14'(i));
    chk("refill_count", 32'(count), 8);
    tim = 14'h3FFF; rdy = 1; clr_ovf = 1;
    step();
    rdy = 0; clr_ovf = 0;
    step();
    chk("ovf_set_wins", 32'(pio_word), 32'hC042);
    chk("ovf_set_wins_valid", 32'(pio_word[VALID_BIT]), 1);
    rst = 1;
    step();
    rst = 0;
    step();
    pulse(14'h1); pulse(14'h2); pulse(14'h3);
    chk("three_count", 32'(count), 3);
    rst = 1;
    step();
    rst = 0;
    chk("mid_reset_count", 32'(count), 0);
    chk("mid_reset_pio", 32'(pio_word), 0);
    step();
    pulse(14'h7);
    chk("post_reset_pio", 32'(pio_word), 32'h4007);
    chk("post_reset_count", 32'(count), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
